noc_output_vc_scheduler: RTL and testbench

// - Per-output-port flit scheduler; sits after the port/VC allocation stage, in front of the output link register.
// - Each cycle it picks one VC whose head flit is valid and that has a downstream credit, and pops that flit.
// - It keeps one credit counter per VC and drives the per-VC vc_ready back into port/VC allocation.
// - The default policy is flit-level round-robin across VCs; an optional packet-lock mode keeps the link on one VC for a whole packet.

---
 rtl/noc_output_vc_scheduler_if.sv | 24 ++
 rtl/noc_output_vc_scheduler.sv | 116 +++++++++++
 tb/tb_noc_output_vc_scheduler.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/noc_output_vc_scheduler_if.sv
// Handshake bundle between VC buffers / allocator (master) and the output VC scheduler (slave).
interface noc_output_vc_scheduler_if #(
    parameter int unsigned CHANNELS = 2
);
    logic [CHANNELS-1:0] vc_valid;
    logic [CHANNELS-1:0] vc_sop;
    logic [CHANNELS-1:0] vc_eop;
    logic [CHANNELS-1:0] credit_return;
    logic [CHANNELS-1:0] vc_pop;
    logic                link_valid;
    logic [CHANNELS-1:0] link_vc;
    logic [CHANNELS-1:0] vc_ready;
    logic                credit_err;

    modport master (
        output vc_valid, vc_sop, vc_eop, credit_return,
        input  vc_pop, link_valid, link_vc, vc_ready, credit_err
    );

    modport slave (
        input  vc_valid, vc_sop, vc_eop, credit_return,
        output vc_pop, link_valid, link_vc, vc_ready, credit_err
    );
endinterface

// File: rtl/noc_output_vc_scheduler.sv
// Per-output-port flit scheduler: credit-gated round-robin pick of one VC per cycle.
// Define NOC_SCHED_PKT_LOCK_EN to hold the link on one VC for a whole packet.
module noc_output_vc_scheduler #(
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned CREDITS  = 4
) (
    input  logic                           noc_clk,
    input  logic                           noc_rst_n,
    noc_output_vc_scheduler_if.slave       bus
);
    localparam int unsigned CNT_W = $clog2(CREDITS + 1);
    localparam int unsigned PTR_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [CNT_W-1:0]      credit_q [CHANNELS];
    logic [CNT_W-1:0]      credit_d [CHANNELS];
    logic [PTR_W-1:0]      rr_q, rr_d;
    logic                  link_valid_q;
    logic [CHANNELS-1:0]   link_vc_q;
    logic                  credit_err_q, credit_err_d;

    logic [CHANNELS-1:0]   ready, lock_ok, elig, rot, rot_pick, pop;
    logic [2*CHANNELS-1:0] elig_dbl, pick_dbl;
    logic [PTR_W-1:0]      win;

`ifdef NOC_SCHED_PKT_LOCK_EN
    typedef enum logic {ST_IDLE, ST_LOCKED} lock_state_e;
    lock_state_e           state_q;
    logic [CHANNELS-1:0]   lock_vc_q;

    assign lock_ok = (state_q == ST_LOCKED) ? lock_vc_q : '1;
`else
    logic unused_pkt_marks;

    assign lock_ok          = '1;
    assign unused_pkt_marks = ^{bus.vc_sop, bus.vc_eop};
`endif

    always_comb begin
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            ready[i] = (credit_q[i] != '0);
        end
    end

    // Rotate so rr_q lands at bit 0, keep the lowest set bit, then rotate back.
    always_comb begin
        elig     = bus.vc_valid & ready & lock_ok;
        elig_dbl = {elig, elig} >> rr_q;
        rot      = elig_dbl[CHANNELS-1:0];
        rot_pick = rot & (~rot + 1'b1);
        pick_dbl = {rot_pick, rot_pick} << rr_q;
        pop      = pick_dbl[2*CHANNELS-1:CHANNELS];
    end

    always_comb begin
        win = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (pop[i]) win = i[PTR_W-1:0];
        end
        rr_d = rr_q;
        if (|pop) rr_d = (win == PTR_W'(CHANNELS - 1)) ? '0 : win + 1'b1;
    end

    always_comb begin
        credit_err_d = credit_err_q;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            credit_d[i] = credit_q[i];
            case ({pop[i], bus.credit_return[i]})
                2'b10: credit_d[i] = credit_q[i] - 1'b1;
                2'b01: begin
                    if (credit_q[i] == CNT_W'(CREDITS)) credit_err_d = 1'b1;
                    else                                credit_d[i] = credit_q[i] + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge noc_clk) begin
        if (!noc_rst_n) begin
            for (int unsigned i = 0; i < CHANNELS; i++) credit_q[i] <= CNT_W'(CREDITS);
            rr_q         <= '0;
            link_valid_q <= 1'b0;
            link_vc_q    <= '0;
            credit_err_q <= 1'b0;
`ifdef NOC_SCHED_PKT_LOCK_EN
            state_q      <= ST_IDLE;
            lock_vc_q    <= '0;
`endif
        end else begin
            credit_q     <= credit_d;
            rr_q         <= rr_d;
            link_valid_q <= |pop;
            link_vc_q    <= pop;
            credit_err_q <= credit_err_d;
`ifdef NOC_SCHED_PKT_LOCK_EN
            if (|pop) begin
                if (state_q == ST_IDLE) begin
                    if (|(bus.vc_sop & pop) && !(|(bus.vc_eop & pop))) begin
                        state_q   <= ST_LOCKED;
                        lock_vc_q <= pop;
                    end
                end else if (|(bus.vc_eop & pop)) begin
                    state_q <= ST_IDLE;
                end
            end
`endif
        end
    end

    assign bus.vc_pop     = pop;
    assign bus.link_valid = link_valid_q;
    assign bus.link_vc    = link_vc_q;
    assign bus.vc_ready   = ready;
    assign bus.credit_err = credit_err_q;

endmodule

// File: tb/tb_noc_output_vc_scheduler.sv
// Bench for noc_output_vc_scheduler (CHANNELS=2, CREDITS=4); lock scenarios run when NOC_SCHED_PKT_LOCK_EN is defined.
module tb_noc_output_vc_scheduler;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    int         m_cnt [2];
    int         m_rr;
    logic       m_err;
    logic       m_locked;
    int         m_lock_vc;
    logic [2:0] sb [$];

    noc_output_vc_scheduler_if #(.CHANNELS(2)) bus ();

    noc_output_vc_scheduler #(
        .CHANNELS (2),
        .CREDITS  (4)
    ) dut (
        .noc_clk   (clk),
        .noc_rst_n (rst_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic [1:0] v, input logic [1:0] s, input logic [1:0] e, input logic [1:0] r);
        bus.vc_valid      = v;
        bus.vc_sop        = s;
        bus.vc_eop        = e;
        bus.credit_return = r;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        drive(2'b00, 2'b00, 2'b00, 2'b00);
        tick();
        rst_n = 1'b1;
    endtask

    // Reference model: predicts the pop at each negedge and queues the expected link beat.
    task automatic monitor_pop();
        logic [1:0] rdy, lok, elig, pop;
        int w;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_cnt[0] = 4; m_cnt[1] = 4; m_rr = 0; m_err = 1'b0;
                m_locked = 1'b0; m_lock_vc = 0;
                sb.delete();
            end else begin
                rdy  = {m_cnt[1] != 0, m_cnt[0] != 0};
                lok  = !m_locked ? 2'b11 : (m_lock_vc == 0 ? 2'b01 : 2'b10);
                elig = bus.vc_valid & rdy & lok;
                w = -1;
                if (m_rr == 0) begin
                    if (elig[0]) w = 0; else if (elig[1]) w = 1;
                end else begin
                    if (elig[1]) w = 1; else if (elig[0]) w = 0;
                end
                pop = (w == 0) ? 2'b01 : (w == 1) ? 2'b10 : 2'b00;
                checks++;
                if (bus.vc_pop !== pop) begin
                    errors++;
                    $display("FAIL sb_pop t=%0t got %b want %b", $time, bus.vc_pop, pop);
                end
                checks++;
                if (bus.vc_ready !== rdy) begin
                    errors++;
                    $display("FAIL sb_ready t=%0t got %b want %b", $time, bus.vc_ready, rdy);
                end
                checks++;
                if (bus.credit_err !== m_err) begin
                    errors++;
                    $display("FAIL sb_credit_err t=%0t got %b want %b", $time, bus.credit_err, m_err);
                end
                sb.push_back({|pop, pop});
                for (int i = 0; i < 2; i++) begin
                    if (pop[i] && !bus.credit_return[i]) m_cnt[i]--;
                    else if (!pop[i] && bus.credit_return[i]) begin
                        if (m_cnt[i] == 4) m_err = 1'b1;
                        else               m_cnt[i]++;
                    end
                end
                if (w >= 0) begin
                    m_rr = (w + 1) % 2;
`ifdef NOC_SCHED_PKT_LOCK_EN
                    if (m_locked) begin
                        if ((w == 0) ? bus.vc_eop[0] : bus.vc_eop[1]) m_locked = 1'b0;
                    end else if (((w == 0) ? bus.vc_sop[0] : bus.vc_sop[1]) &&
                                 !((w == 0) ? bus.vc_eop[0] : bus.vc_eop[1])) begin
                        m_locked  = 1'b1;
                        m_lock_vc = w;
                    end
`endif
                end
            end
        end
    endtask

    task automatic monitor_link();
        logic [2:0] exp;
        forever begin
            @(posedge clk);
            #2;
            if (sb.size() > 0) begin
                exp = sb.pop_front();
                checks++;
                if ({bus.link_valid, bus.link_vc} !== exp) begin
                    errors++;
                    $display("FAIL sb_link t=%0t got %b/%b want %b/%b", $time,
                             bus.link_valid, bus.link_vc, exp[2], exp[1:0]);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(2'b11, 2'b00, 2'b00, 2'b00);
        tick();
        drive(2'b00, 2'b00, 2'b00, 2'b00);
        #1;
        checks++;
        if (bus.vc_ready !== 2'b11) begin errors++; $display("FAIL reset_ready got %b want 11", bus.vc_ready); end
        checks++;
        if (bus.link_valid !== 1'b0) begin errors++; $display("FAIL reset_link_valid got %b want 0", bus.link_valid); end
        checks++;
        if (bus.link_vc !== 2'b00) begin errors++; $display("FAIL reset_link_vc got %b want 00", bus.link_vc); end
        checks++;
        if (bus.credit_err !== 1'b0) begin errors++; $display("FAIL reset_credit_err got %b want 0", bus.credit_err); end
        checks++;
        if (bus.vc_pop !== 2'b00) begin errors++; $display("FAIL reset_pop got %b want 00", bus.vc_pop); end
        rst_n = 1'b1;
    endtask

    task automatic test_round_robin();
        logic [1:0] want;
        pulse_reset();
        for (int c = 0; c < 10; c++) begin
            drive(2'b11, 2'b00, 2'b00, 2'b00);
            #3;
            want = (c >= 8) ? 2'b00 : ((c % 2 == 0) ? 2'b01 : 2'b10);
            checks++;
            if (bus.vc_pop !== want) begin
                errors++;
                $display("FAIL rr_pop cycle %0d got %b want %b", c, bus.vc_pop, want);
            end
            tick();
        end
        drive(2'b00, 2'b00, 2'b00, 2'b00);
        checks++;
        if (bus.vc_ready !== 2'b00) begin errors++; $display("FAIL rr_drained_ready got %b want 00", bus.vc_ready); end
        for (int c = 0; c < 4; c++) begin
            drive(2'b00, 2'b00, 2'b00, 2'b11);
            tick();
        end
        drive(2'b00, 2'b00, 2'b00, 2'b00);
        checks++;
        if (bus.vc_ready !== 2'b11 || bus.credit_err !== 1'b0) begin
            errors++;
            $display("FAIL rr_refill got %b/%b want 11/0", bus.vc_ready, bus.credit_err);
        end
    endtask

    task automatic test_pop_and_return();
        pulse_reset();
        for (int c = 0; c < 3; c++) begin
            drive(2'b10, 2'b00, 2'b00, 2'b00);
            tick();
        end
        drive(2'b10, 2'b00, 2'b00, 2'b10);
        #3;
        checks++;
        if (bus.vc_pop !== 2'b10) begin errors++; $display("FAIL popret_pop got %b want 10", bus.vc_pop); end
        tick();
        drive(2'b00, 2'b00, 2'b00, 2'b00);
        checks++;
        if (bus.vc_ready !== 2'b11) begin errors++; $display("FAIL popret_ready got %b want 11", bus.vc_ready); end
        drive(2'b10, 2'b00, 2'b00, 2'b00);
        tick();
        drive(2'b10, 2'b00, 2'b00, 2'b00);
        #3;
        checks++;
        if (bus.vc_ready !== 2'b01 || bus.vc_pop !== 2'b00) begin
            errors++;
            $display("FAIL empty_vc got ready %b pop %b want ready 01 pop 00", bus.vc_ready, bus.vc_pop);
        end
        tick();
        drive(2'b00, 2'b00, 2'b00, 2'b10);
        tick();
        drive(2'b00, 2'b00, 2'b00, 2'b00);
        checks++;
        if (bus.vc_ready !== 2'b11) begin errors++; $display("FAIL return_ready got %b want 11", bus.vc_ready); end
    endtask

    task automatic test_credit_overflow();
        pulse_reset();
        drive(2'b00, 2'b00, 2'b00, 2'b01);
        tick();
        drive(2'b00, 2'b00, 2'b00, 2'b00);
        checks++;
        if (bus.credit_err !== 1'b1 || bus.vc_ready !== 2'b11) begin
            errors++;
            $display("FAIL overflow got err %b ready %b want err 1 ready 11", bus.credit_err, bus.vc_ready);
        end
        drive(2'b01, 2'b00, 2'b00, 2'b00); tick(); tick();
        drive(2'b00, 2'b00, 2'b00, 2'b01); tick(); tick();
        drive(2'b00, 2'b00, 2'b00, 2'b00);
        checks++;
        if (bus.credit_err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b want 1", bus.credit_err); end
        rst_n = 1'b0;
        tick();
        checks++;
        if (bus.credit_err !== 1'b0) begin errors++; $display("FAIL err_reset_clear got %b want 0", bus.credit_err); end
        rst_n = 1'b1;
    endtask

`ifdef NOC_SCHED_PKT_LOCK_EN
    task automatic test_pkt_lock();
        logic [1:0] v [4] = '{2'b11, 2'b11, 2'b11, 2'b10};
        logic [1:0] s [4] = '{2'b01, 2'b00, 2'b00, 2'b10};
        logic [1:0] e [4] = '{2'b00, 2'b00, 2'b01, 2'b10};
        logic [1:0] w [4] = '{2'b01, 2'b01, 2'b01, 2'b10};
        pulse_reset();
        for (int c = 0; c < 4; c++) begin
            drive(v[c], s[c], e[c], 2'b00);
            #3;
            checks++;
            if (bus.vc_pop !== w[c]) begin errors++; $display("FAIL lock_pop cycle %0d got %b want %b", c, bus.vc_pop, w[c]); end
            tick();
        end
    endtask

    task automatic test_lock_stall();
        logic [1:0] v [5] = '{2'b11, 2'b10, 2'b10, 2'b11, 2'b10};
        logic [1:0] s [5] = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b10};
        logic [1:0] e [5] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b10};
        logic [1:0] w [5] = '{2'b01, 2'b00, 2'b00, 2'b01, 2'b10};
        pulse_reset();
        for (int c = 0; c < 5; c++) begin
            drive(v[c], s[c], e[c], 2'b00);
            #3;
            checks++;
            if (bus.vc_pop !== w[c]) begin errors++; $display("FAIL stall_pop cycle %0d got %b want %b", c, bus.vc_pop, w[c]); end
            tick();
        end
    endtask

    task automatic test_reset_mid_lock();
        pulse_reset();
        drive(2'b01, 2'b01, 2'b00, 2'b00); tick();
        drive(2'b01, 2'b00, 2'b00, 2'b00); tick(); tick();
        rst_n = 1'b0;
        drive(2'b10, 2'b00, 2'b00, 2'b00);
        tick();
        rst_n = 1'b1;
        #3;
        checks++;
        if (bus.vc_pop !== 2'b10 || bus.vc_ready !== 2'b11) begin
            errors++;
            $display("FAIL reset_unlock got pop %b ready %b want pop 10 ready 11", bus.vc_pop, bus.vc_ready);
        end
        tick();
    endtask
`else
    task automatic test_no_lock();
        pulse_reset();
        drive(2'b11, 2'b01, 2'b00, 2'b00);
        #3;
        checks++;
        if (bus.vc_pop !== 2'b01) begin errors++; $display("FAIL nolock_first got %b want 01", bus.vc_pop); end
        tick();
        drive(2'b11, 2'b00, 2'b00, 2'b00);
        #3;
        checks++;
        if (bus.vc_pop !== 2'b10) begin errors++; $display("FAIL nolock_interleave got %b want 10", bus.vc_pop); end
        tick();
    endtask
`endif

    task automatic test_back_to_back();
        logic [1:0] r;
        pulse_reset();
        for (int c = 0; c < 300; c++) begin
            r[0] = ($urandom_range(0, 2) == 0) && (m_cnt[0] < 4);
            r[1] = ($urandom_range(0, 2) == 0) && (m_cnt[1] < 4);
            drive(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), r);
            tick();
        end
        drive(2'b00, 2'b00, 2'b00, 2'b00);
        tick();
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        drive(2'b00, 2'b00, 2'b00, 2'b00);
        fork
            monitor_pop();
            monitor_link();
        join_none
        tick();
        test_reset();
        test_round_robin();
        test_pop_and_return();
        test_credit_overflow();
`ifdef NOC_SCHED_PKT_LOCK_EN
        test_pkt_lock();
        test_lock_stall();
        test_reset_mid_lock();
`else
        test_no_lock();
`endif
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
